sweep_sequencer: RTL and testbench

Sequences one DAC-step / ADC-sample sweep for the curve tracer. Steps the DAC code from a start to a stop value and waits a programmable settle time after each update. It then requests one ADC conversion (four with averaging) and hands each (code, sample) pair downstream through a valid/ready handshake toward the UART framer. It sits between the host command decoder and the DAC/ADC interface blocks, which run off the clock divider's outputs.

---
 rtl/sweep_pkg.sv | 20 ++
 rtl/sweep_accum.sv | 47 ++++
 rtl/sweep_sequencer.sv | 145 ++++++++++++++
 tb/tb_sweep_sequencer.sv | 428 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sweep_pkg.sv
// sweep_pkg: state encoding, default widths and averaging constants shared by the
// sweep sequencer and its sample accumulator.
package sweep_pkg;

    localparam int DAC_W_DEF    = 12;
    localparam int ADC_W_DEF    = 12;
    localparam int SETTLE_W_DEF = 16;
    localparam int AVG_COUNT    = 4;
    localparam int AVG_SHIFT    = 2;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        EMIT   = 3'd4,
        STEP   = 3'd5
    } sweep_state_t;

endpackage

// File: rtl/sweep_accum.sv
// sweep_accum: captures ADC conversion results. With SWEEP_AVG_EN defined it sums
// AVG_COUNT conversions and presents their truncated mean; otherwise it holds one sample.
module sweep_accum
    import sweep_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF
) (
    input  logic             globalclock,
    input  logic             rst,
    input  logic             clear,
    input  logic             add,
    input  logic [ADC_W-1:0] data,
    output logic [ADC_W-1:0] result
);

`ifdef SWEEP_AVG_EN
    logic [ADC_W+AVG_SHIFT-1:0] sum;

    always_ff @(posedge globalclock or negedge rst) begin
        if (!rst) begin
            sum <= '0;
        end else if (clear) begin
            sum <= '0;
        end else if (add) begin
            sum <= sum + (ADC_W+AVG_SHIFT)'(data);
        end
    end

    // Dropping the low bits divides by AVG_COUNT and truncates.
    assign result = sum[ADC_W+AVG_SHIFT-1:AVG_SHIFT];
`else
    logic [ADC_W-1:0] sample_r;

    always_ff @(posedge globalclock or negedge rst) begin
        if (!rst) begin
            sample_r <= '0;
        end else if (clear) begin
            sample_r <= '0;
        end else if (add) begin
            sample_r <= data;
        end
    end

    assign result = sample_r;
`endif

endmodule

// File: rtl/sweep_sequencer.sv
// sweep_sequencer: steps the DAC from cfg_start to cfg_stop, settles, samples the ADC and
// emits {code, sample} pairs. Define SWEEP_AVG_EN to average four conversions per point.
module sweep_sequencer
    import sweep_pkg::*;
#(
    parameter int DAC_W    = DAC_W_DEF,
    parameter int ADC_W    = ADC_W_DEF,
    parameter int SETTLE_W = SETTLE_W_DEF
) (
    input  logic                   globalclock,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [DAC_W-1:0]       cfg_start,
    input  logic [DAC_W-1:0]       cfg_stop,
    input  logic [DAC_W-1:0]       cfg_step,
    input  logic [SETTLE_W-1:0]    cfg_settle,
    output logic [DAC_W-1:0]       dac_code,
    output logic                   dac_load,
    output logic                   adc_req,
    input  logic                   adc_ack,
    input  logic [ADC_W-1:0]       adc_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DAC_W+ADC_W-1:0] out_data,
    output logic                   busy,
    output logic                   done,
    output sweep_state_t           dbg_state
);

    // Handshakes: a transfer happens on a cycle where valid (adc_req / out_valid) and
    // ready (adc_ack / out_ready) are both high; valid and its data hold until then.

    sweep_state_t          state, state_nx;
    logic [DAC_W-1:0]      code;
    logic [DAC_W-1:0]      stop_r;
    logic [DAC_W-1:0]      step_r;
    logic [SETTLE_W-1:0]   settle_r;
    logic [SETTLE_W-1:0]   settle_cnt;
    logic [DAC_W:0]        next_code;
    logic                  last_point;
    logic                  conv_ack;
    logic                  sample_done;
    logic                  acc_clear;
    logic                  acc_add;
    logic [ADC_W-1:0]      sample;

    // One extra bit so a step past all-ones shows up as a carry instead of wrapping.
    assign next_code  = {1'b0, code} + {1'b0, step_r};
    assign last_point = next_code[DAC_W] || (next_code[DAC_W-1:0] > stop_r);

`ifdef SWEEP_AVG_EN
    logic [1:0] avg_cnt;
    logic       req_gap;

    assign adc_req     = (state == SAMPLE) && !req_gap;
    assign conv_ack    = adc_req && adc_ack;
    assign sample_done = conv_ack && (avg_cnt == 2'(AVG_COUNT - 1));

    // req_gap forces one idle cycle on adc_req between the conversions of a point.
    always_ff @(posedge globalclock or negedge rst) begin
        if (!rst) begin
            avg_cnt <= '0;
            req_gap <= 1'b0;
        end else if (state != SAMPLE) begin
            avg_cnt <= '0;
            req_gap <= 1'b0;
        end else if (req_gap) begin
            req_gap <= 1'b0;
        end else if (conv_ack) begin
            avg_cnt <= avg_cnt + 2'd1;
            req_gap <= 1'b1;
        end
    end
`else
    assign adc_req     = (state == SAMPLE);
    assign conv_ack    = adc_req && adc_ack;
    assign sample_done = conv_ack;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = LOAD;
            LOAD:    state_nx = SETTLE;
            SETTLE:  if (settle_cnt == '0) state_nx = SAMPLE;
            SAMPLE:  if (sample_done) state_nx = EMIT;
            EMIT:    if (out_ready) state_nx = STEP;
            STEP:    state_nx = last_point ? IDLE : LOAD;
            default: state_nx = IDLE;
        endcase
        if (abort) state_nx = IDLE;
    end

    always_ff @(posedge globalclock or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            code       <= '0;
            stop_r     <= '0;
            step_r     <= '0;
            settle_r   <= '0;
            settle_cnt <= '0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            done  <= (state == STEP) && last_point && !abort;
            if (state == IDLE && state_nx == LOAD) begin
                code     <= cfg_start;
                stop_r   <= cfg_stop;
                step_r   <= (cfg_step == '0) ? DAC_W'(1) : cfg_step;
                settle_r <= cfg_settle;
            end else if (state == STEP && state_nx == LOAD) begin
                code <= next_code[DAC_W-1:0];
            end
            if (state == LOAD) begin
                settle_cnt <= settle_r;
            end else if (state == SETTLE && settle_cnt != '0) begin
                settle_cnt <= settle_cnt - SETTLE_W'(1);
            end
        end
    end

    // Each point starts from an empty accumulator; abort also discards partial sums.
    assign acc_clear = abort || (state == LOAD);
    assign acc_add   = conv_ack && !abort;

    sweep_accum #(
        .ADC_W (ADC_W)
    ) u_accum (
        .globalclock (globalclock),
        .rst         (rst),
        .clear       (acc_clear),
        .add         (acc_add),
        .data        (adc_data),
        .result      (sample)
    );

    assign dac_code  = code;
    assign dac_load  = (state == LOAD);
    assign out_valid = (state == EMIT);
    assign out_data  = {code, sample};
    assign busy      = (state != IDLE);
    assign dbg_state = state;

endmodule

// File: tb/tb_sweep_sequencer.sv
// tb_sweep_sequencer: directed sweeps against a queue-based model of the expected points,
// with a per-cycle monitor for latencies, handshake stability and done/busy behaviour.
module tb_sweep_sequencer;

    localparam int DAC_W    = 12;
    localparam int ADC_W    = 12;
    localparam int SETTLE_W = 16;
    localparam int OUT_W    = DAC_W + ADC_W;
`ifdef SWEEP_AVG_EN
    localparam int N_CONV = 4;
`else
    localparam int N_CONV = 1;
`endif

    logic                globalclock = 1'b0;
    logic                rst         = 1'b0;
    logic                start       = 1'b0;
    logic                abort       = 1'b0;
    logic [DAC_W-1:0]    cfg_start   = '0;
    logic [DAC_W-1:0]    cfg_stop    = '0;
    logic [DAC_W-1:0]    cfg_step    = '0;
    logic [SETTLE_W-1:0] cfg_settle  = '0;
    logic                adc_ack     = 1'b0;
    logic [ADC_W-1:0]    adc_data    = '0;
    logic                out_ready   = 1'b1;
    logic [DAC_W-1:0]    dac_code;
    logic                dac_load;
    logic                adc_req;
    logic                out_valid;
    logic [OUT_W-1:0]    out_data;
    logic                busy;
    logic                done;
    sweep_pkg::sweep_state_t dbg_state;

    sweep_sequencer #(
        .DAC_W    (DAC_W),
        .ADC_W    (ADC_W),
        .SETTLE_W (SETTLE_W)
    ) dut (
        .globalclock (globalclock),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .cfg_start   (cfg_start),
        .cfg_stop    (cfg_stop),
        .cfg_step    (cfg_step),
        .cfg_settle  (cfg_settle),
        .dac_code    (dac_code),
        .dac_load    (dac_load),
        .adc_req     (adc_req),
        .adc_ack     (adc_ack),
        .adc_data    (adc_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .done        (done),
        .dbg_state   (dbg_state)
    );

    // ---------------- clock / cycle counter ----------------
    initial forever #5 globalclock = ~globalclock;

    int cyc = 0;
    always @(posedge globalclock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    int n_checks = 0;
    int n_errors = 0;

    logic [OUT_W-1:0] exp_q[$];
    logic [DAC_W-1:0] load_q[$];
    logic [ADC_W-1:0] adc_q[$];
    logic [ADC_W-1:0] dir_q[$];
    logic [OUT_W-1:0] got_q[$];

    int cur_settle = 0;
    int ack_delay  = 1;
    int bp_target  = 0;
    bit noise_en   = 1'b0;

    int load_cnt = 0;
    int done_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] got_code(input int i);
        if (i < got_q.size()) return 16'(got_q[i][OUT_W-1:ADC_W]);
        return 16'hFFFF;
    endfunction

    // ---------------- ADC responder ----------------
    initial begin : adc_responder
        int wait_cnt;
        wait_cnt = -1;
        forever begin
            @(negedge globalclock);
            if (!rst) begin
                adc_ack  = 1'b0;
                wait_cnt = -1;
            end else if (adc_ack) begin
                adc_ack = 1'b0;
            end else if (adc_req) begin
                if (wait_cnt < 0) wait_cnt = ack_delay;
                if (wait_cnt == 0) begin
                    adc_ack = 1'b1;
                    if (adc_q.size() > 0) adc_data = adc_q.pop_front();
                    else adc_data = '0;
                    wait_cnt = -1;
                end else begin
                    wait_cnt--;
                end
            end else begin
                wait_cnt = -1;
                if (noise_en) begin
                    adc_ack  = 1'b1;
                    adc_data = 12'hBAD;
                end
            end
        end
    end

    // ---------------- output sink ----------------
    initial begin : sink
        int held;
        held = 0;
        forever begin
            @(negedge globalclock);
            if (!busy) held = 0;
            if (out_valid && held < bp_target) begin
                out_ready = 1'b0;
                held++;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    // ---------------- per-cycle monitor ----------------
    initial begin : monitor
        int  start_cyc, hs_cyc, load_cyc, ack_cyc, req_rises;
        bit  req_first;
        logic prev_req, prev_ack, prev_abort, prev_valid, prev_ready, prev_busy;
        logic [OUT_W-1:0] prev_data;
        start_cyc = -1; hs_cyc = -1; load_cyc = 0; ack_cyc = 0; req_rises = 0;
        req_first = 1'b0;
        prev_req = 0; prev_ack = 0; prev_abort = 0; prev_valid = 0; prev_ready = 0;
        prev_busy = 0; prev_data = '0;
        forever begin
            @(negedge globalclock);
            #1;
            if (!rst) begin
                start_cyc = -1; hs_cyc = -1; req_first = 1'b0;
                prev_req = 0; prev_ack = 0; prev_abort = 0; prev_valid = 0;
                prev_ready = 0; prev_busy = 0; prev_data = '0;
                continue;
            end
            if (start && !abort && !busy) start_cyc = cyc;
            if (dac_load) begin
                load_cnt++;
                if (start_cyc >= 0) begin
                    check("start_to_load", cyc - start_cyc, 1);
                    start_cyc = -1;
                end
                if (hs_cyc >= 0) begin
                    check("hs_to_load", cyc - hs_cyc, 2);
                    hs_cyc = -1;
                end
                if (load_q.size() > 0) check("load_code", dac_code, load_q.pop_front());
                else check("load_unexpected", 1, 0);
                load_cyc  = cyc;
                req_first = 1'b1;
                req_rises = 0;
            end
            if (adc_req && !prev_req) begin
                req_rises++;
                if (req_first) begin
                    check("load_to_req", cyc - load_cyc, cur_settle + 2);
                    req_first = 1'b0;
                end
            end
            if (prev_req && !prev_ack && !prev_abort) check("req_held", adc_req, 1);
            if (adc_req && adc_ack) ack_cyc = cyc;
            if (out_valid && !prev_valid) begin
                check("ack_to_valid", cyc - ack_cyc, 1);
                check("reqs_per_point", req_rises, N_CONV);
            end
            if (prev_valid && !prev_ready && !prev_abort) begin
                check("valid_held", out_valid, 1);
                check("data_held", out_data, prev_data);
            end
            if (out_valid && out_ready) begin
                got_q.push_back(out_data);
                if (exp_q.size() > 0) check("out_data", out_data, exp_q.pop_front());
                else check("out_unexpected", 1, 0);
                hs_cyc = cyc;
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
                check("busy_before_done", prev_busy, 1);
            end
            if (!busy && !dac_load) hs_cyc = -1;
            prev_req = adc_req; prev_ack = adc_ack; prev_abort = abort;
            prev_valid = out_valid; prev_ready = out_ready; prev_busy = busy;
            prev_data = out_data;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_cycles(input int n);
        repeat (n) @(negedge globalclock);
    endtask

    task automatic clear_queues();
        exp_q.delete(); load_q.delete(); adc_q.delete(); got_q.delete();
    endtask

    // Model: list of points start, start+step, ... while <= stop and <= all-ones.
    task automatic build_model(input int s, input int e, input int st);
        int c, n, stp, sum;
        logic [ADC_W-1:0] v;
        stp = (st == 0) ? 1 : st;
        c = s;
        forever begin
            load_q.push_back(c[DAC_W-1:0]);
            sum = 0;
            for (int k = 0; k < N_CONV; k++) begin
                if (dir_q.size() > 0) v = dir_q.pop_front();
                else v = ADC_W'($urandom_range(0, 4095));
                adc_q.push_back(v);
                sum += int'(v);
            end
            exp_q.push_back({c[DAC_W-1:0], ADC_W'(sum / N_CONV)});
            n = c + stp;
            if (n > 4095 || n > e) break;
            c = n;
        end
    endtask

    task automatic pulse_start(input int s, input int e, input int st, input int settle);
        cfg_start  = DAC_W'(s);
        cfg_stop   = DAC_W'(e);
        cfg_step   = DAC_W'(st);
        cfg_settle = SETTLE_W'(settle);
        cur_settle = settle;
        start = 1'b1;
        @(negedge globalclock);
        start = 1'b0;
        // Scramble the configuration: a running sweep must ignore it.
        cfg_start  = DAC_W'($urandom_range(0, 4095));
        cfg_stop   = DAC_W'($urandom_range(0, 4095));
        cfg_step   = DAC_W'($urandom_range(0, 4095));
        cfg_settle = SETTLE_W'($urandom_range(0, 65535));
    endtask

    task automatic run_sweep(input string tag, input int s, input int e, input int st,
                             input int settle, input int bp, input bit noise);
        int d0, budget;
        clear_queues();
        build_model(s, e, st);
        bp_target = bp;
        noise_en  = noise;
        d0 = done_cnt;
        pulse_start(s, e, st, settle);
        budget = 3000;
        while (done_cnt == d0 && budget > 0) begin
            @(negedge globalclock);
            budget--;
        end
        check({tag, "_done_seen"}, (budget > 0) ? 1 : 0, 1);
        wait_cycles(3);
        check({tag, "_done_once"}, done_cnt - d0, 1);
        check({tag, "_exp_drained"}, exp_q.size(), 0);
        check({tag, "_loads_drained"}, load_q.size(), 0);
        noise_en  = 1'b0;
        bp_target = 0;
    endtask

    // ---------------- main sequence ----------------
    initial begin : main
        int l0, d0, budget;

        wait_cycles(3);
        check("rst_dac_code", dac_code, 0);
        check("rst_dac_load", dac_load, 0);
        check("rst_adc_req", adc_req, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_state", dbg_state, sweep_pkg::IDLE);
        rst = 1'b1;
        wait_cycles(2);

        run_sweep("basic", 0, 4, 2, 3, 0, 0);
        check("basic_n", got_q.size(), 3);
        check("basic_c0", got_code(0), 16'h000);
        check("basic_c1", got_code(1), 16'h002);
        check("basic_c2", got_code(2), 16'h004);

        run_sweep("overshoot", 1, 6, 2, 0, 0, 0);
        check("overshoot_n", got_q.size(), 3);
        check("overshoot_c2", got_code(2), 16'h005);

        run_sweep("step0", 5, 7, 0, 1, 0, 0);
        check("step0_n", got_q.size(), 3);
        check("step0_c0", got_code(0), 16'h005);
        check("step0_c1", got_code(1), 16'h006);
        check("step0_c2", got_code(2), 16'h007);

        run_sweep("carry", 12'hFFE, 12'hFFF, 2, 2, 0, 0);
        check("carry_n", got_q.size(), 1);
        check("carry_c0", got_code(0), 16'hFFE);
        check("carry_code_kept", dac_code, 12'hFFE);

        run_sweep("reverse", 9, 3, 1, 1, 0, 0);
        check("reverse_n", got_q.size(), 1);
        check("reverse_c0", got_code(0), 16'h009);

        run_sweep("backpressure", 0, 2, 1, 2, 10, 0);
        check("bp_n", got_q.size(), 3);

        run_sweep("noise", 3, 9, 3, 4, 0, 1);
        check("noise_c2", got_code(2), 16'h009);

        ack_delay = 3;
        run_sweep("slow_ack", 100, 130, 15, 0, 0, 0);
        check("slow_ack_c1", got_code(1), 16'd115);
        ack_delay = 1;

        // Averaging directed values: 10, 11, 12, 14 average to 11; one conversion keeps 10.
        dir_q.delete();
        dir_q.push_back(12'd10); dir_q.push_back(12'd11);
        dir_q.push_back(12'd12); dir_q.push_back(12'd14);
        run_sweep("avg", 7, 7, 1, 2, 0, 0);
        dir_q.delete();
`ifdef SWEEP_AVG_EN
        check("avg_pair", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, {12'd7, 12'd11});
`else
        check("avg_pair", (got_q.size() > 0) ? 32'(got_q[0]) : 32'hDEAD, {12'd7, 12'd10});
`endif

        // Abort during SETTLE of the second point.
        clear_queues();
        build_model(0, 10, 1);
        l0 = load_cnt;
        d0 = done_cnt;
        pulse_start(0, 10, 1, 20);
        budget = 500;
        while (load_cnt < l0 + 2 && budget > 0) begin
            @(negedge globalclock);
            budget--;
        end
        check("abort_reach_p2", (budget > 0) ? 1 : 0, 1);
        wait_cycles(5);
        abort = 1'b1;
        @(negedge globalclock);
        abort = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_adc_req", adc_req, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_dac_code", dac_code, 1);
        wait_cycles(10);
        check("abort_no_done", done_cnt - d0, 0);
        check("abort_one_output", got_q.size(), 1);
        clear_queues();

        // Start and abort together in IDLE: nothing starts.
        l0 = load_cnt;
        start = 1'b1;
        abort = 1'b1;
        @(negedge globalclock);
        start = 1'b0;
        abort = 1'b0;
        wait_cycles(5);
        check("start_abort_no_load", load_cnt - l0, 0);
        check("start_abort_idle", busy, 0);

        // Asynchronous reset while waiting for a slow conversion.
        ack_delay = 30;
        clear_queues();
        build_model(5, 9, 1);
        pulse_start(5, 9, 1, 1);
        budget = 200;
        while (!adc_req && budget > 0) begin
            @(negedge globalclock);
            budget--;
        end
        check("rst_reach_sample", (budget > 0) ? 1 : 0, 1);
        wait_cycles(3);
        #2 rst = 1'b0;
        #1;
        check("arst_dac_code", dac_code, 0);
        check("arst_dac_load", dac_load, 0);
        check("arst_adc_req", adc_req, 0);
        check("arst_out_valid", out_valid, 0);
        check("arst_out_data", out_data, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        wait_cycles(2);
        rst = 1'b1;
        ack_delay = 1;
        clear_queues();
        wait_cycles(3);
        check("post_rst_idle", busy, 0);

        run_sweep("after_reset", 20, 22, 1, 0, 0, 0);
        check("after_reset_n", got_q.size(), 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
